// File: rtl/user_proj_gate_sched_if.sv
// Gate scheduler bus: entry/exit requests with their passcode, plus occupancy and gate status.
// The master drives requests; the scheduler (slave) reports state back.
interface user_proj_gate_sched_if;
  logic [7:0] passcode_in;
  logic       enter_req;
  logic       exit_req;
  logic [4:0] car_count;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       full;
  logic       empty;
  logic       lockout;

  modport master (
    output passcode_in, enter_req, exit_req,
    input  car_count, entry_gate_open, exit_gate_open, full, empty, lockout
  );

  modport slave (
    input  passcode_in, enter_req, exit_req,
    output car_count, entry_gate_open, exit_gate_open, full, empty, lockout
  );
endinterface

// File: rtl/user_proj_gate_sched.sv
// Parking-lot gate scheduler: one-deep request latches per direction, round-robin grant,
// passcode check with fail counting and entry lockout, and saturating occupancy.
module user_proj_gate_sched #(
  parameter int         CAPACITY       = 20,
  parameter logic [7:0] PASSCODE       = 8'hFF,
  parameter int         GATE_CYCLES    = 4,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  user_proj_gate_sched_if.slave   bus
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_ONE  = GW'(1);
  localparam logic [GW-1:0] GATE_ZERO = GW'(0);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
  localparam logic [LW-1:0] LOCK_ZERO = LW'(0);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [FW-1:0] FAIL_ONE  = FW'(1);
  localparam logic [FW-1:0] FAIL_ZERO = FW'(0);
  localparam logic [4:0]    CAP       = 5'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

  state_t       state_r;
  logic [GW-1:0] gate_cnt_r;
  logic [LW-1:0] lock_cnt_r;
  logic [FW-1:0] fail_cnt_r;
  logic [4:0]   car_count_r;
  logic [7:0]   code_r;
  logic         enter_pend_r;
  logic         exit_pend_r;
  logic         favour_exit_r;
  logic         entry_gate_r;
  logic         exit_gate_r;
  logic         lockout_r;

  logic         full_s;
  logic         empty_s;
  logic         grant_entry_s;
  logic         grant_exit_s;
  logic         code_ok_s;
  logic         entry_ok_s;
  logic         bad_code_s;
  logic         exit_ok_s;

  assign full_s  = (car_count_r == CAP);
  assign empty_s = (car_count_r == 5'd0);

  // Grant arbitration in IDLE; a rejected grant still consumes the pending request.
  always_comb begin
    grant_entry_s = 1'b0;
    grant_exit_s  = 1'b0;
    if (state_r == IDLE) begin
      if (enter_pend_r && (!exit_pend_r || !favour_exit_r)) begin
        grant_entry_s = 1'b1;
      end else if (exit_pend_r) begin
        grant_exit_s = 1'b1;
      end else begin
        grant_entry_s = 1'b0;
        grant_exit_s  = 1'b0;
      end
    end else begin
      grant_entry_s = 1'b0;
      grant_exit_s  = 1'b0;
    end
    code_ok_s  = (code_r == PASSCODE);
    entry_ok_s = grant_entry_s && !full_s && code_ok_s;
    bad_code_s = grant_entry_s && !full_s && !code_ok_s;
    exit_ok_s  = grant_exit_s && !empty_s;
  end

  // Request latches: set only while clear, entry suppressed during lockout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_pend_r <= 1'b0;
      exit_pend_r  <= 1'b0;
      code_r       <= 8'h00;
    end else begin
      if (enter_pend_r) begin
        if (grant_entry_s) enter_pend_r <= 1'b0;
      end else if (bus.enter_req && !lockout_r) begin
        enter_pend_r <= 1'b1;
        code_r       <= bus.passcode_in;
      end
      if (exit_pend_r) begin
        if (grant_exit_s) exit_pend_r <= 1'b0;
      end else if (bus.exit_req) begin
        exit_pend_r <= 1'b1;
      end
    end
  end

  // Gate FSM: the gate register rises on the grant edge and holds for GATE_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      gate_cnt_r    <= GATE_ZERO;
      car_count_r   <= 5'd0;
      entry_gate_r  <= 1'b0;
      exit_gate_r   <= 1'b0;
      favour_exit_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (entry_ok_s) begin
            state_r      <= ENTRY_OPEN;
            entry_gate_r <= 1'b1;
            gate_cnt_r   <= GATE_LAST;
            car_count_r  <= car_count_r + 5'd1;
          end else if (exit_ok_s) begin
            state_r     <= EXIT_OPEN;
            exit_gate_r <= 1'b1;
            gate_cnt_r  <= GATE_LAST;
            car_count_r <= car_count_r - 5'd1;
          end
          if (grant_entry_s) begin
            favour_exit_r <= 1'b1;
          end else if (grant_exit_s) begin
            favour_exit_r <= 1'b0;
          end
        end
        ENTRY_OPEN, EXIT_OPEN: begin
          if (gate_cnt_r == GATE_ZERO) begin
            state_r      <= IDLE;
            entry_gate_r <= 1'b0;
            exit_gate_r  <= 1'b0;
          end else begin
            gate_cnt_r <= gate_cnt_r - GATE_ONE;
          end
        end
        default: begin
          state_r      <= IDLE;
          entry_gate_r <= 1'b0;
          exit_gate_r  <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive wrong-code counter and lockout timer; full-lot rejections leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_cnt_r <= FAIL_ZERO;
      lockout_r  <= 1'b0;
      lock_cnt_r <= LOCK_ZERO;
    end else begin
      if (lockout_r) begin
        if (lock_cnt_r == LOCK_ZERO) begin
          lockout_r <= 1'b0;
        end else begin
          lock_cnt_r <= lock_cnt_r - LOCK_ONE;
        end
      end
      if (bad_code_s) begin
        if (fail_cnt_r == FAIL_LAST) begin
          fail_cnt_r <= FAIL_ZERO;
          lockout_r  <= 1'b1;
          lock_cnt_r <= LOCK_LAST;
        end else begin
          fail_cnt_r <= fail_cnt_r + FAIL_ONE;
        end
      end else if (entry_ok_s) begin
        fail_cnt_r <= FAIL_ZERO;
      end
    end
  end

  assign bus.car_count       = car_count_r;
  assign bus.entry_gate_open = entry_gate_r;
  assign bus.exit_gate_open  = exit_gate_r;
  assign bus.lockout         = lockout_r;
  assign bus.full            = full_s;
  assign bus.empty           = empty_s;

endmodule

// File: tb/tb_user_proj_gate_sched.sv
// Self-checking bench for user_proj_gate_sched: expected gate openings go into a scoreboard
// queue when a request is driven and are popped by a monitor when a gate rises.
module tb_user_proj_gate_sched;

  localparam int CAP = 20;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   lock_runs;

  typedef struct packed {
    logic       is_entry;
    logic [4:0] count;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic prev_e, prev_x, prev_l;
  int   run_e, run_x, run_l;

  user_proj_gate_sched_if gs_if ();

  user_proj_gate_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard on every gate rise and measures gate/lockout pulse widths.
  always @(negedge clk) begin
    if (reset) begin
      prev_e = 1'b0; prev_x = 1'b0; prev_l = 1'b0;
      run_e = 0; run_x = 0; run_l = 0;
    end else begin
      if (gs_if.entry_gate_open || gs_if.exit_gate_open) begin
        tests_run++;
        if ((gs_if.entry_gate_open && gs_if.exit_gate_open) !== 1'b0) begin
          tests_failed++;
          $display("FAIL both_gates: entry=%0b exit=%0b required not both high",
                   gs_if.entry_gate_open, gs_if.exit_gate_open);
        end
      end
      if (gs_if.entry_gate_open && !prev_e) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL entry_open: unexpected entry gate opening, count=%0d", gs_if.car_count);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.is_entry !== 1'b1 || gs_if.car_count !== mon_e.count) begin
            tests_failed++;
            $display("FAIL entry_open: got dir=entry count=%0d, required dir_entry=%0b count=%0d",
                     gs_if.car_count, mon_e.is_entry, mon_e.count);
          end
        end
      end
      if (gs_if.exit_gate_open && !prev_x) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL exit_open: unexpected exit gate opening, count=%0d", gs_if.car_count);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.is_entry !== 1'b0 || gs_if.car_count !== mon_e.count) begin
            tests_failed++;
            $display("FAIL exit_open: got dir=exit count=%0d, required dir_entry=%0b count=%0d",
                     gs_if.car_count, mon_e.is_entry, mon_e.count);
          end
        end
      end
      if (gs_if.entry_gate_open) run_e++;
      else if (prev_e) begin
        tests_run++;
        if (run_e !== 4) begin
          tests_failed++;
          $display("FAIL entry_width: got %0d cycles, required 4", run_e);
        end
        run_e = 0;
      end
      if (gs_if.exit_gate_open) run_x++;
      else if (prev_x) begin
        tests_run++;
        if (run_x !== 4) begin
          tests_failed++;
          $display("FAIL exit_width: got %0d cycles, required 4", run_x);
        end
        run_x = 0;
      end
      if (gs_if.lockout) run_l++;
      else if (prev_l) begin
        tests_run++;
        lock_runs++;
        if (run_l !== 16) begin
          tests_failed++;
          $display("FAIL lockout_width: got %0d cycles, required 16", run_l);
        end
        run_l = 0;
      end
      prev_e = gs_if.entry_gate_open;
      prev_x = gs_if.exit_gate_open;
      prev_l = gs_if.lockout;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One request pulse; checks latency, final count and that the scoreboard drained.
  task automatic do_req(input bit is_entry, input logic [7:0] code,
                        input bit expect_open, input logic [4:0] exp_count);
    exp_t e;
    logic gate_now;
    if (expect_open) begin
      e.is_entry = is_entry;
      e.count    = exp_count;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    if (is_entry) begin
      gs_if.enter_req   = 1'b1;
      gs_if.passcode_in = code;
    end else begin
      gs_if.exit_req = 1'b1;
    end
    @(posedge clk); #1;
    gs_if.enter_req = 1'b0;
    gs_if.exit_req  = 1'b0;
    gate_now = is_entry ? gs_if.entry_gate_open : gs_if.exit_gate_open;
    tests_run++;
    if (gate_now !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_gate: got %0b on latch cycle, required 0", gate_now);
    end
    @(posedge clk); #1;
    gate_now = is_entry ? gs_if.entry_gate_open : gs_if.exit_gate_open;
    tests_run++;
    if (gate_now !== expect_open) begin
      tests_failed++;
      $display("FAIL gate_latency: got %0b, required %0b (entry=%0b)", gate_now, expect_open, is_entry);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (gs_if.car_count !== exp_count || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL car_count: got %0d (pending exp %0d), required %0d (pending 0)",
               gs_if.car_count, sb_q.size(), exp_count);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    tests_run++;
    if (gs_if.car_count !== 5'd0 || gs_if.entry_gate_open !== 1'b0 || gs_if.exit_gate_open !== 1'b0 ||
        gs_if.empty !== 1'b1 || gs_if.full !== 1'b0 || gs_if.lockout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got count=%0d eg=%0b xg=%0b empty=%0b full=%0b lock=%0b, required 0 0 0 1 0 0",
               gs_if.car_count, gs_if.entry_gate_open, gs_if.exit_gate_open,
               gs_if.empty, gs_if.full, gs_if.lockout);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_entry();
    do_req(1'b1, 8'hFF, 1'b1, 5'd1);
    tests_run++;
    if (gs_if.empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_after_entry: got %0b, required 0", gs_if.empty);
    end
  endtask

  task automatic test_lockout();
    lock_runs = 0;
    do_req(1'b1, 8'h00, 1'b0, 5'd1);
    do_req(1'b1, 8'h00, 1'b0, 5'd1);
    tests_run++;
    if (gs_if.lockout !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_lockout: got %0b after two wrong codes, required 0", gs_if.lockout);
    end
    do_req(1'b1, 8'h00, 1'b0, 5'd1);
    tests_run++;
    if (gs_if.lockout !== 1'b1) begin
      tests_failed++;
      $display("FAIL lockout_on: got %0b, required 1", gs_if.lockout);
    end
    do_req(1'b1, 8'hFF, 1'b0, 5'd1);
    do_req(1'b0, 8'h00, 1'b1, 5'd0);
    tests_run++;
    if (gs_if.lockout !== 1'b0 || lock_runs != 1) begin
      tests_failed++;
      $display("FAIL lockout_end: got lockout=%0b runs=%0d, required 0 and 1", gs_if.lockout, lock_runs);
    end
    do_req(1'b1, 8'hFF, 1'b1, 5'd1);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 1; i <= CAP; i++) begin
      do_req(1'b1, 8'hFF, 1'b1, 5'(i));
    end
    tests_run++;
    if (gs_if.full !== 1'b1 || gs_if.empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_flag: got full=%0b empty=%0b, required 1 0", gs_if.full, gs_if.empty);
    end
    do_req(1'b1, 8'hFF, 1'b0, 5'(CAP));
    tests_run++;
    if (gs_if.full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_hold: got %0b, required 1", gs_if.full);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   waited;
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      do_req(1'b1, 8'hFF, 1'b1, 5'(i));
    end
    do_req(1'b0, 8'h00, 1'b1, 5'd5);
    e.is_entry = 1'b1; e.count = 5'd6; sb_q.push_back(e);
    e.is_entry = 1'b0; e.count = 5'd5; sb_q.push_back(e);
    @(posedge clk); #1;
    gs_if.enter_req   = 1'b1;
    gs_if.exit_req    = 1'b1;
    gs_if.passcode_in = 8'hFF;
    @(posedge clk); #1;
    gs_if.enter_req = 1'b0;
    gs_if.exit_req  = 1'b0;
    waited = 0;
    while ((sb_q.size() != 0 || gs_if.entry_gate_open || gs_if.exit_gate_open) && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    tests_run++;
    if (sb_q.size() != 0 || gs_if.car_count !== 5'd5) begin
      tests_failed++;
      $display("FAIL simultaneous: got count=%0d pending=%0d after %0d cycles, required 5 and 0",
               gs_if.car_count, sb_q.size(), waited);
    end
  endtask

  task automatic test_empty_exit();
    apply_reset();
    do_req(1'b0, 8'h00, 1'b0, 5'd0);
    tests_run++;
    if (gs_if.empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_exit: got empty=%0b, required 1", gs_if.empty);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    apply_reset();
    e.is_entry = 1'b1; e.count = 5'd1; sb_q.push_back(e);
    @(posedge clk); #1;
    gs_if.enter_req   = 1'b1;
    gs_if.passcode_in = 8'hFF;
    @(posedge clk); #1;
    gs_if.enter_req = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (gs_if.entry_gate_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_open: got gate=%0b, required 1", gs_if.entry_gate_open);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (gs_if.entry_gate_open !== 1'b0 || gs_if.car_count !== 5'd0 || gs_if.empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_abort: got gate=%0b count=%0d empty=%0b, required 0 0 1",
               gs_if.entry_gate_open, gs_if.car_count, gs_if.empty);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (gs_if.entry_gate_open !== 1'b0 || gs_if.car_count !== 5'd0 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL no_replay: got gate=%0b count=%0d pending=%0d, required 0 0 0",
               gs_if.entry_gate_open, gs_if.car_count, sb_q.size());
    end
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    lock_runs         = 0;
    reset             = 1'b1;
    gs_if.enter_req   = 1'b0;
    gs_if.exit_req    = 1'b0;
    gs_if.passcode_in = 8'h00;
    test_reset();
    test_basic_entry();
    test_lockout();
    test_full();
    test_back_to_back();
    test_empty_exit();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
